gpu: RTL and testbench

GPU -- requirements
Module: gpu

---
 rtl/gpu.sv | 218 +++++++++++++++++++++
 tb/tb_gpu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpu.sv
// Simple raster GPU: an APB-written register file feeding a pixel-per-cycle fill
// engine that draws single pixels, filled rectangles or the whole screen.
module gpu #(
  parameter int unsigned WIDTH_BITS   = 10,
  parameter int unsigned HEIGHT_BITS  = 9,
  parameter int unsigned CHANNEL_BITS = 8,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [31:0]             pAddr_i,
  input  logic [31:0]             pDataWrite_i,
  input  logic                    pSel_i,
  input  logic                    pEnable_i,
  input  logic                    pWrite_i,
  output logic [WIDTH_BITS-1:0]   x_o,
  output logic [HEIGHT_BITS-1:0]  y_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic                    data_avail
);

  localparam int unsigned ColorBits = 3 * CHANNEL_BITS;
  localparam logic [WIDTH_BITS-1:0]  XLast = WIDTH_BITS'(H_RES - 1);
  localparam logic [HEIGHT_BITS-1:0] YLast = HEIGHT_BITS'(V_RES - 1);

  localparam logic [2:0] RegX0    = 3'd0;
  localparam logic [2:0] RegY0    = 3'd1;
  localparam logic [2:0] RegX1    = 3'd2;
  localparam logic [2:0] RegY1    = 3'd3;
  localparam logic [2:0] RegColor = 3'd4;
  localparam logic [2:0] RegCmd   = 3'd5;

  localparam logic [1:0] CmdNop   = 2'd0;
  localparam logic [1:0] CmdPixel = 2'd1;
  localparam logic [1:0] CmdRect  = 2'd2;

  typedef enum logic [0:0] {StIdle, StDraw} state_e;

  function automatic logic [WIDTH_BITS-1:0] clip_x(input logic [WIDTH_BITS-1:0] v);
    return (v > XLast) ? XLast : v;
  endfunction

  function automatic logic [HEIGHT_BITS-1:0] clip_y(input logic [HEIGHT_BITS-1:0] v);
    return (v > YLast) ? YLast : v;
  endfunction

  // Programming registers
  logic [WIDTH_BITS-1:0]  r_x0, r_x1;
  logic [HEIGHT_BITS-1:0] r_y0, r_y1;
  logic [ColorBits-1:0]   r_color;

  // Active-command shadow and raster counters
  logic [WIDTH_BITS-1:0]  r_xmin, r_xmax, r_cx;
  logic [HEIGHT_BITS-1:0] r_ymin, r_ymax, r_cy;
  logic [ColorBits-1:0]   r_scolor;

  // Registered pixel outputs
  logic [WIDTH_BITS-1:0]   r_xo;
  logic [HEIGHT_BITS-1:0]  r_yo;
  logic [CHANNEL_BITS-1:0] r_red, r_grn, r_blu;
  logic                    r_avail;

  state_e r_state, w_state_next;

  logic                   w_wr, w_start, w_emit, w_last;
  logic [2:0]             w_reg_sel;
  logic [1:0]             w_cmd;
  logic [WIDTH_BITS-1:0]  w_x0c, w_x1c, w_xmin, w_xmax;
  logic [HEIGHT_BITS-1:0] w_y0c, w_y1c, w_ymin, w_ymax;
  logic                   w_unused_bits;

  assign w_wr      = pSel_i & pEnable_i & pWrite_i;
  assign w_reg_sel = pAddr_i[4:2];
  assign w_cmd     = pDataWrite_i[1:0];
  assign w_last    = (r_cx == r_xmax) && (r_cy == r_ymax);

  // Only address bits [4:2] are decoded; the rest are deliberately ignored.
  assign w_unused_bits = ^{pAddr_i, pDataWrite_i};

  assign w_x0c = clip_x(r_x0);
  assign w_x1c = clip_x(r_x1);
  assign w_y0c = clip_y(r_y0);
  assign w_y1c = clip_y(r_y1);

  // Bounding box of the command being launched, corners normalised
  always_comb begin
    w_xmin = '0;
    w_xmax = XLast;
    w_ymin = '0;
    w_ymax = YLast;
    case (w_cmd)
      CmdPixel: begin
        w_xmin = w_x0c;
        w_xmax = w_x0c;
        w_ymin = w_y0c;
        w_ymax = w_y0c;
      end
      CmdRect: begin
        w_xmin = (w_x0c < w_x1c) ? w_x0c : w_x1c;
        w_xmax = (w_x0c < w_x1c) ? w_x1c : w_x0c;
        w_ymin = (w_y0c < w_y1c) ? w_y0c : w_y1c;
        w_ymax = (w_y0c < w_y1c) ? w_y1c : w_y0c;
      end
      default: ;  // CLEAR keeps the full-screen defaults
    endcase
  end

  // Next-state logic: commands are only accepted while idle
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_emit       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_wr && (w_reg_sel == RegCmd) && (w_cmd != CmdNop)) begin
          w_start      = 1'b1;
          w_state_next = StDraw;
        end
      end
      StDraw: begin
        w_emit = 1'b1;
        if (w_last) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // APB register file; stays writable during a draw
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_color <= '0;
    end else if (w_wr) begin
      case (w_reg_sel)
        RegX0:    r_x0    <= pDataWrite_i[WIDTH_BITS-1:0];
        RegY0:    r_y0    <= pDataWrite_i[HEIGHT_BITS-1:0];
        RegX1:    r_x1    <= pDataWrite_i[WIDTH_BITS-1:0];
        RegY1:    r_y1    <= pDataWrite_i[HEIGHT_BITS-1:0];
        RegColor: r_color <= pDataWrite_i[ColorBits-1:0];
        default:  ;
      endcase
    end
  end

  // Shadow latch on launch, then raster walk x-inner / y-outer
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_xmin   <= '0;
      r_xmax   <= '0;
      r_ymin   <= '0;
      r_ymax   <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_scolor <= '0;
    end else if (w_start) begin
      r_xmin   <= w_xmin;
      r_xmax   <= w_xmax;
      r_ymin   <= w_ymin;
      r_ymax   <= w_ymax;
      r_cx     <= w_xmin;
      r_cy     <= w_ymin;
      r_scolor <= r_color;
    end else if (w_emit && !w_last) begin
      if (r_cx == r_xmax) begin
        r_cx <= r_xmin;
        r_cy <= r_cy + HEIGHT_BITS'(1);
      end else begin
        r_cx <= r_cx + WIDTH_BITS'(1);
      end
    end
  end

  // Output registers; hold the last pixel while nothing is being emitted
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_xo    <= '0;
      r_yo    <= '0;
      r_red   <= '0;
      r_grn   <= '0;
      r_blu   <= '0;
      r_avail <= 1'b0;
    end else begin
      r_avail <= w_emit;
      if (w_emit) begin
        r_xo  <= r_cx;
        r_yo  <= r_cy;
        r_red <= r_scolor[3*CHANNEL_BITS-1 -: CHANNEL_BITS];
        r_grn <= r_scolor[2*CHANNEL_BITS-1 -: CHANNEL_BITS];
        r_blu <= r_scolor[CHANNEL_BITS-1:0];
      end
    end
  end

  assign x_o        = r_xo;
  assign y_o        = r_yo;
  assign r_o        = r_red;
  assign g_o        = r_grn;
  assign b_o        = r_blu;
  assign data_avail = r_avail;

endmodule

// File: tb/tb_gpu.sv
// Directed testbench for gpu: APB programming, pixel capture and checks.
module tb_gpu;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] paddr, pwdata;
  logic        psel, pen, pwr;
  logic [9:0]  x_o;
  logic [8:0]  y_o;
  logic [7:0]  r_o, g_o, b_o;
  logic        data_avail;

  gpu dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .pAddr_i     (paddr),
    .pDataWrite_i(pwdata),
    .pSel_i      (psel),
    .pEnable_i   (pen),
    .pWrite_i    (pwr),
    .x_o         (x_o),
    .y_o         (y_o),
    .r_o         (r_o),
    .g_o         (g_o),
    .b_o         (b_o),
    .data_avail  (data_avail)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int rgb;
    int c;
  } pix_t;

  pix_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   last_edge = 0;

  // Edge counter and pixel capture on the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (data_avail === 1'b1) begin
      q.push_back('{x: int'(x_o), y: int'(y_o), rgb: int'({r_o, g_o, b_o}), c: cyc});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    paddr = a;
    pwdata = d;
    psel = 1'b1;
    pen = 1'b1;
    pwr = 1'b1;
    @(posedge clk);
    #1;
    psel = 1'b0;
    pen = 1'b0;
    pwr = 1'b0;
    last_edge = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_pix(input string tag, input int idx, input int x, input int y,
                         input int rgb, input int c);
    if (idx < q.size()) begin
      check({tag, "_x"}, q[idx].x, x);
      check({tag, "_y"}, q[idx].y, y);
      check({tag, "_rgb"}, q[idx].rgb, rgb);
      check({tag, "_cyc"}, q[idx].c, c);
    end else begin
      check({tag, "_present"}, q.size(), idx + 1);
    end
  endtask

  int k0;

  initial begin
    n_rst = 1'b1;
    psel = 1'b0;
    pen = 1'b0;
    pwr = 1'b0;
    paddr = '0;
    pwdata = '0;

    // Reset for one edge
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    check("rst_x", x_o, 0);
    check("rst_y", y_o, 0);
    check("rst_r", r_o, 0);
    check("rst_g", g_o, 0);
    check("rst_b", b_o, 0);
    check("rst_avail", data_avail, 0);

    // Single pixel
    q.delete();
    apb_wr(32'h00, 5);
    apb_wr(32'h04, 7);
    apb_wr(32'h10, 32'hFF8000);
    apb_wr(32'h14, 1);
    k0 = last_edge;
    wait_cycles(6);
    check("pix_count", q.size(), 1);
    chk_pix("pix", 0, 5, 7, 32'hFF8000, k0 + 1);
    check("hold_avail", data_avail, 0);
    check("hold_x", x_o, 5);
    check("hold_r", r_o, 255);

    // Swapped-corner rectangle
    q.delete();
    apb_wr(32'h00, 3);
    apb_wr(32'h08, 1);
    apb_wr(32'h04, 2);
    apb_wr(32'h0C, 1);
    apb_wr(32'h10, 32'h010203);
    apb_wr(32'h14, 2);
    k0 = last_edge;
    wait_cycles(10);
    check("rect_count", q.size(), 6);
    chk_pix("rect0", 0, 1, 1, 32'h010203, k0 + 1);
    chk_pix("rect1", 1, 2, 1, 32'h010203, k0 + 2);
    chk_pix("rect2", 2, 3, 1, 32'h010203, k0 + 3);
    chk_pix("rect3", 3, 1, 2, 32'h010203, k0 + 4);
    chk_pix("rect4", 4, 2, 2, 32'h010203, k0 + 5);
    chk_pix("rect5", 5, 3, 2, 32'h010203, k0 + 6);

    // 4x4 rectangle with CMD and COLOR written while drawing
    q.delete();
    apb_wr(32'h00, 0);
    apb_wr(32'h04, 0);
    apb_wr(32'h08, 3);
    apb_wr(32'h0C, 3);
    apb_wr(32'h10, 32'h112233);
    apb_wr(32'h14, 2);
    k0 = last_edge;
    apb_wr(32'h10, 32'hAABBCC);
    apb_wr(32'h14, 1);
    wait_cycles(25);
    check("busy_count", q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk_pix($sformatf("busy%0d", i), i, i % 4, i / 4, 32'h112233, k0 + 1 + i);
    end

    // Clipping; also confirms the mid-draw COLOR write landed in the register
    q.delete();
    apb_wr(32'h00, 700);
    apb_wr(32'h04, 500);
    apb_wr(32'h14, 1);
    k0 = last_edge;
    wait_cycles(6);
    check("clip_count", q.size(), 1);
    chk_pix("clip", 0, 639, 479, 32'hAABBCC, k0 + 1);

    // New CMD accepted in the idle cycle right after the last pixel
    q.delete();
    apb_wr(32'h00, 10);
    apb_wr(32'h04, 20);
    apb_wr(32'h14, 1);
    k0 = last_edge;
    apb_wr(32'h00, 11);
    apb_wr(32'h14, 1);
    wait_cycles(6);
    check("b2b_count", q.size(), 2);
    chk_pix("b2b0", 0, 10, 20, 32'hAABBCC, k0 + 1);
    chk_pix("b2b1", 1, 11, 20, 32'hAABBCC, k0 + 3);

    // Reset in the middle of a CLEAR
    q.delete();
    apb_wr(32'h10, 32'h445566);
    apb_wr(32'h14, 3);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (q.size() >= 10) break;
    end
    check("clr_reached10", q.size() >= 10, 1);
    chk_pix("clr9", 9, 9, 0, 32'h445566, last_edge + 10);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    n_rst = 1'b0;
    check("abort_avail", data_avail, 0);
    check("abort_x", x_o, 0);
    check("abort_r", r_o, 0);
    wait_cycles(5);
    check("abort_count", q.size(), 10);

    q.delete();
    apb_wr(32'h00, 2);
    apb_wr(32'h04, 3);
    apb_wr(32'h10, 32'h0F0F0F);
    apb_wr(32'h14, 1);
    k0 = last_edge;
    wait_cycles(6);
    check("post_count", q.size(), 1);
    chk_pix("post", 0, 2, 3, 32'h0F0F0F, k0 + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
